fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reset/IRQ vector loads, opcode and operand fetch,
// and the execution-unit handshake, all on a one-hot FSM with registered outputs.
module fetch_sequencer #(
    parameter int                 ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC = 16'hFFFC,
    parameter logic [ADDR_W-1:0]  IRQ_VEC   = 16'hFFFE
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    input  logic [1:0]        op_len,
    input  logic              irq_n,
    input  logic              irq_mask,
    output logic              exec_valid,
    input  logic              exec_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [7:0]        ir,
    output logic [15:0]       oper,
    output logic [ADDR_W-1:0] pc,
    output logic              irq_ack,
    output logic              halted
);

    typedef enum logic [9:0] {
        S_RESET   = 10'b00_0000_0001,
        S_VEC_LO  = 10'b00_0000_0010,
        S_VEC_HI  = 10'b00_0000_0100,
        S_FETCH   = 10'b00_0000_1000,
        S_OPER_LO = 10'b00_0001_0000,
        S_OPER_HI = 10'b00_0010_0000,
        S_EXEC    = 10'b00_0100_0000,
        S_IRQ_LO  = 10'b00_1000_0000,
        S_IRQ_HI  = 10'b01_0000_0000,
        S_HALT    = 10'b10_0000_0000
    } state_t;

    state_t            state;
    // FETCH spends one extra cycle with no read so op_len reflects the new ir
    logic              decode;
    logic [ADDR_W-1:0] pc_inc, vec_lo, vec_hi, jump_pc;
    logic              irq_take;

    assign pc_inc   = pc + ADDR_W'(1);
    assign vec_lo   = ADDR_W'(mem_rdata);
    assign vec_hi   = ADDR_W'({mem_rdata, pc[7:0]});
    assign jump_pc  = pc_load ? pc_load_val : pc;
    assign irq_take = !irq_n && !irq_mask;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_RESET;
            decode     <= 1'b0;
            pc         <= '0;
            ir         <= 8'hEA;
            oper       <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            exec_valid <= 1'b0;
            irq_ack    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            irq_ack <= 1'b0;
            unique case (state)
                S_RESET: begin
                    state    <= S_VEC_LO;
                    mem_rd   <= 1'b1;
                    mem_addr <= RESET_VEC;
                end
                S_VEC_LO: if (mem_ready) begin
                    pc       <= vec_lo;
                    state    <= S_VEC_HI;
                    mem_addr <= RESET_VEC + ADDR_W'(1);
                end
                S_VEC_HI: if (mem_ready) begin
                    pc       <= vec_hi;
                    state    <= S_FETCH;
                    mem_addr <= vec_hi;
                end
                S_FETCH: begin
                    if (decode) begin
                        decode <= 1'b0;
                        case (op_len)
                            2'd0: begin
                                state      <= S_EXEC;
                                exec_valid <= 1'b1;
                            end
                            2'd3: begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                            default: begin
                                state    <= S_OPER_LO;
                                mem_rd   <= 1'b1;
                                mem_addr <= pc;
                            end
                        endcase
                    end else if (mem_ready) begin
                        ir       <= mem_rdata;
                        oper     <= '0;
                        pc       <= pc_inc;
                        decode   <= 1'b1;
                        mem_rd   <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                S_OPER_LO: if (mem_ready) begin
                    oper[7:0] <= mem_rdata;
                    pc        <= pc_inc;
                    if (op_len == 2'd2) begin
                        state    <= S_OPER_HI;
                        mem_addr <= pc_inc;
                    end else begin
                        state      <= S_EXEC;
                        mem_rd     <= 1'b0;
                        mem_addr   <= '0;
                        exec_valid <= 1'b1;
                    end
                end
                S_OPER_HI: if (mem_ready) begin
                    oper[15:8] <= mem_rdata;
                    pc         <= pc_inc;
                    state      <= S_EXEC;
                    mem_rd     <= 1'b0;
                    mem_addr   <= '0;
                    exec_valid <= 1'b1;
                end
                S_EXEC: if (exec_ready) begin
                    exec_valid <= 1'b0;
                    pc         <= jump_pc;
                    mem_rd     <= 1'b1;
                    if (irq_take) begin
                        state    <= S_IRQ_LO;
                        irq_ack  <= 1'b1;
                        mem_addr <= IRQ_VEC;
                    end else begin
                        state    <= S_FETCH;
                        mem_addr <= jump_pc;
                    end
                end
                S_IRQ_LO: if (mem_ready) begin
                    pc       <= vec_lo;
                    state    <= S_IRQ_HI;
                    mem_addr <= IRQ_VEC + ADDR_W'(1);
                end
                S_IRQ_HI: if (mem_ready) begin
                    pc       <= vec_hi;
                    state    <= S_FETCH;
                    mem_addr <= vec_hi;
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state    <= S_RESET;
                    mem_rd   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule
